uart_rx_frame: RTL
==================

# uart_rx_frame

UART receive stage: the downstream consumer of the transmit block's serial line. Oversamples `i_Rx_Serial` with the system clock and samples at mid-bit. Reassembles 8N1 frames (optionally 8E1/8O1) LSB first. Presents each received byte with a one-cycle valid strobe plus framing and parity status to the register/bridge logic behind it.

## Interface
- `CLKS_PER_BIT`, 437: system clocks per bit; legal range 4..2047, matching the transmitter's setting.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity; used only when `UART_RX_PARITY_EN` is defined.
- `i_Clock`  in  1  system clock; all logic on the rising edge.
- `i_Rst_n`  in  1  asynchronous active-low reset.
- `i_Rx_Serial`  in  1  asynchronous serial line; idles high.
- `o_Rx_DV`  out  1  one-cycle strobe: frame complete; byte and error flags valid.
- `o_Rx_Byte`  out  8  last received byte; held until the next frame completes.
- `o_Rx_Frame_Err`  out  1  stop bit sampled low on the last frame; held like `o_Rx_Byte`.
- `o_Rx_Parity_Err`  out  1  parity mismatch on the last frame; held; constant 0 when parity is compiled out.
- `o_Rx_Active`  out  1  high from start-bit detection until the cycle after the stop-bit sample.

## Operation
- **Synchroniser:** 2-FF synchroniser on `i_Rx_Serial`, both stages reset to 1. All decisions use the stage-2 output `rx_s`.
- **Counter:** `r_Clock_Count` is 11 bits. `HALF = (CLKS_PER_BIT-1)/2`, integer division.
- **IDLE:** count=0, bit index=0. If `rx_s`=0, go to START and set `o_Rx_Active`=1.
- **START:** increment count until count==HALF. At that point, if `rx_s`=0, clear count and go to DATA. If `rx_s`=1, treat it as a glitch: go to IDLE and set `o_Rx_Active`=0; no strobe.
- **DATA:**
  - Increment count while count < CLKS_PER_BIT-1.
  - At count==CLKS_PER_BIT-1, shift `rx_s` into the shift register at the bit index and clear count.
  - After bit 7, go to PARITY if compiled in, else STOP.
- **PARITY:** same timing as one data bit. Captures the parity bit.
- **STOP:**
  - Same timing as one data bit.
  - At the sample point:
    - load `o_Rx_Byte` from the shift register;
    - set `o_Rx_Frame_Err` = ~`rx_s`;
    - set `o_Rx_Parity_Err` to the parity check result;
    - assert `o_Rx_DV`.
  - Next state is CLEANUP if `rx_s`=1, else WAIT_IDLE.
- **CLEANUP:** one cycle; deassert `o_Rx_DV` and `o_Rx_Active`, then go to IDLE.
- **WAIT_IDLE:**
  - Entry cycle: deassert `o_Rx_DV` and `o_Rx_Active`.
  - Stay until `rx_s`=1, then go to IDLE. A held-low break line produces exactly one error frame, not repeated frames.
- **Error flags:** both flags update only on the `o_Rx_DV` edge. The byte is delivered even when an error flag is set.
- **No back-pressure:** the consumer must capture the byte on the `o_Rx_DV` cycle. The byte stays valid until the next strobe.

## Timing
- **Reset values:** `o_Rx_DV`=0, `o_Rx_Byte`=8'h00, `o_Rx_Frame_Err`=0, `o_Rx_Parity_Err`=0, `o_Rx_Active`=0. State=IDLE, counters=0.
- **Reset mid-frame:** the partial frame is discarded, with no strobe. Held outputs return to their reset values.
- **Latency:** edge 0 is the first rising edge at which `i_Rx_Serial` is low. IDLE→START occurs on edge 2.
- **Start check:** on edge 3+HALF.
- **Data bit n:** sampled on edge 3+HALF+(n+1)·CLKS_PER_BIT. Net of the 2-cycle synchroniser, this is mid-bit.
- **Strobe:** `o_Rx_DV` is high in the cycle after edge 3+HALF+(9+P)·CLKS_PER_BIT, where P=1 with parity and 0 without.
- **Back-to-back frames:** IDLE is re-entered 1 cycle after the stop sample. A new start edge arriving half a bit after the stop sample is therefore accepted.

## Configuration
- **`UART_RX_PARITY_EN` defined:**
  - adds the PARITY state;
  - the frame is 11 bits;
  - `o_Rx_Parity_Err` = (XOR of data bits XOR parity bit) != `PARITY_ODD`.
- **Not defined:**
  - no PARITY state;
  - the frame is 10 bits;
  - `o_Rx_Parity_Err` is tied to 0;
  - `PARITY_ODD` is ignored.

## Test plan
All scenarios use CLKS_PER_BIT=16, HALF=7, driven by a bit-accurate serial model.

- **Good frame:** 8N1 frame 0xA5 → `o_Rx_DV` high exactly in the cycle after edge 154; `o_Rx_Byte`=0xA5; both error flags 0; `o_Rx_Active` is 1 from edge 2 to edge 154 inclusive.
- **Back-to-back:** frames 0x00 then 0xFF with no idle gap → two strobes 160 cycles apart; bytes 0x00 then 0xFF; no errors.
- **Glitch and break:**
  - a 4-cycle low glitch → START aborts on edge 10; no strobe; `o_Rx_Active` returns to 0.
  - line held low for 40 bit times → exactly one strobe with `o_Rx_Byte`=0x00 and `o_Rx_Frame_Err`=1; next strobe only after the line returns high and a new frame is sent.
- **Reset mid-frame:** pulse `i_Rst_n` low at bit 4 of 0x3C → all outputs at reset values; no strobe; a following frame 0x81 is received correctly.
- **Parity (with `UART_RX_PARITY_EN`, `PARITY_ODD`=0):**
  - 0x07 with parity bit 1 → strobe after edge 170; no error.
  - 0x07 with parity bit 0 → `o_Rx_Parity_Err`=1; `o_Rx_Byte`=0x07.

Source files
------------

// File: rtl/uart_rx_frame_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_rx_frame_if                                                |
// | Purpose  : Serial line input and received-byte status bundle for the       |
// |            UART receive stage.                                             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface uart_rx_frame_if;
  logic       i_Rx_Serial;
  logic       o_Rx_DV;
  logic [7:0] o_Rx_Byte;
  logic       o_Rx_Frame_Err;
  logic       o_Rx_Parity_Err;
  logic       o_Rx_Active;

  // Line driver / byte consumer side.
  modport master (
    output i_Rx_Serial,
    input  o_Rx_DV,
    input  o_Rx_Byte,
    input  o_Rx_Frame_Err,
    input  o_Rx_Parity_Err,
    input  o_Rx_Active
  );

  // Receiver side.
  modport slave (
    input  i_Rx_Serial,
    output o_Rx_DV,
    output o_Rx_Byte,
    output o_Rx_Frame_Err,
    output o_Rx_Parity_Err,
    output o_Rx_Active
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_frame.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_rx_frame                                                   |
// | Purpose  : UART receiver, mid-bit sampling, 8N1 or (UART_RX_PARITY_EN)     |
// |            8E1/8O1, one-cycle valid strobe with framing/parity status.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module uart_rx_frame #(
  parameter int CLKS_PER_BIT = 437,
  parameter bit PARITY_ODD   = 1'b0
) (
  input wire logic       i_Clock,
  input wire logic       i_Rst_n,
  uart_rx_frame_if.slave rx_if
);

  localparam logic [10:0] LAST = 11'(CLKS_PER_BIT - 1);
  localparam logic [10:0] HALF = 11'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_CLEANUP   = 3'd5,
    S_WAIT_IDLE = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic        rx_meta_q, rx_s_q;
  logic [10:0] count_q, count_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  data_q, data_d;
  logic        par_q, par_d;
  logic [7:0]  byte_q, byte_d;
  logic        ferr_q, ferr_d;
  logic        perr_q, perr_d;
  logic        dv_q, dv_d;
  logic        active_q, active_d;
  logic        par_err;

  // Both stages reset high so a reset never looks like a start edge.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_if.i_Rx_Serial;
      rx_s_q    <= rx_meta_q;
    end
  end

`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = S_PARITY;
  assign par_err = ((^data_q) ^ par_q) != PARITY_ODD;
`else
  localparam state_t AFTER_DATA = S_STOP;
  logic unused_parity_cfg;
  assign par_err           = 1'b0;
  assign unused_parity_cfg = par_q ^ PARITY_ODD;
`endif

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= 11'd0;
      bit_idx_q <= 3'd0;
      data_q    <= 8'h00;
      par_q     <= 1'b0;
      byte_q    <= 8'h00;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      dv_q      <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      par_q     <= par_d;
      byte_q    <= byte_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
      dv_q      <= dv_d;
      active_q  <= active_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    par_d     = par_q;
    byte_d    = byte_q;
    ferr_d    = ferr_q;
    perr_d    = perr_q;
    dv_d      = 1'b0;
    active_d  = active_q;

    case (state_q)
      S_IDLE: begin
        count_d   = 11'd0;
        bit_idx_d = 3'd0;
        if (!rx_s_q) begin
          state_d  = S_START;
          active_d = 1'b1;
        end
      end

      S_START: begin
        if (count_q == HALF) begin
          count_d = 11'd0;
          if (!rx_s_q) begin
            state_d = S_DATA;
          end else begin
            state_d  = S_IDLE;
            active_d = 1'b0;
          end
        end else begin
          count_d = count_q + 11'd1;
        end
      end

      S_DATA: begin
        if (count_q < LAST) begin
          count_d = count_q + 11'd1;
        end else begin
          count_d           = 11'd0;
          data_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = 3'd0;
            state_d   = AFTER_DATA;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

      S_PARITY: begin
        if (count_q < LAST) begin
          count_d = count_q + 11'd1;
        end else begin
          count_d = 11'd0;
          par_d   = rx_s_q;
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        if (count_q < LAST) begin
          count_d = count_q + 11'd1;
        end else begin
          count_d = 11'd0;
          byte_d  = data_q;
          ferr_d  = ~rx_s_q;
          perr_d  = par_err;
          dv_d    = 1'b1;
          // A low stop bit may be a break: wait for the line to idle first.
          state_d = rx_s_q ? S_CLEANUP : S_WAIT_IDLE;
        end
      end

      S_CLEANUP: begin
        active_d = 1'b0;
        state_d  = S_IDLE;
      end

      S_WAIT_IDLE: begin
        active_d = 1'b0;
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d  = S_IDLE;
        active_d = 1'b0;
      end
    endcase
  end

  assign rx_if.o_Rx_DV         = dv_q;
  assign rx_if.o_Rx_Byte       = byte_q;
  assign rx_if.o_Rx_Frame_Err  = ferr_q;
  assign rx_if.o_Rx_Parity_Err = perr_q;
  assign rx_if.o_Rx_Active     = active_q;

endmodule
`default_nettype wire
